// File: rtl/bin2dec.sv
`default_nettype none
// ============================================================================
// Module   : bin2dec
// Brief    : 7-bit binary to two-digit BCD with saturation at 99 and a
//            registered, display-multiplexed digit output (4'hF = blank).
// Revision : 1.0 - initial release
// ============================================================================
module bin2dec (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [6:0] i_bin,
  input  logic       i_tens,
  input  logic       i_ones,
  output logic [3:0] o_dec
);

  localparam logic [6:0] C_SAT_LIMIT = 7'd100;
  localparam logic [7:0] C_SAT_BCD   = 8'h99;
  localparam logic [3:0] C_BLANK     = 4'hF;
  localparam logic [3:0] C_ADJ_MIN   = 4'd5;
  localparam logic [3:0] C_ADJ_ADD   = 4'd3;

  logic [7:0] w_bcd_raw;
  logic [7:0] w_bcd;
  logic [3:0] w_sel;
  logic [3:0] r_dec;

  // Unrolled shift-add-3: the loop is fully static, so this is one
  // combinational cone, not a multi-cycle sequence.
  always_comb begin : p_dabble
    logic [14:0] v_work;
    v_work = {8'd0, i_bin};
    for (int k = 0; k < 7; k++) begin
      if (v_work[10:7] >= C_ADJ_MIN) begin
        v_work[10:7] = v_work[10:7] + C_ADJ_ADD;
      end
      if (v_work[14:11] >= C_ADJ_MIN) begin
        v_work[14:11] = v_work[14:11] + C_ADJ_ADD;
      end
      v_work = v_work << 1;
    end
    w_bcd_raw = v_work[14:7];
  end

  // Inputs 100..127 would give a three-digit result; clamp to "99".
  assign w_bcd = (i_bin >= C_SAT_LIMIT) ? C_SAT_BCD : w_bcd_raw;

  always_comb begin
    w_sel = C_BLANK;
    case ({i_tens, i_ones})
      2'b01:   w_sel = w_bcd[3:0];
      2'b10:   w_sel = w_bcd[7:4];
      default: w_sel = C_BLANK;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_dec <= C_BLANK;
    end else begin
      r_dec <= w_sel;
    end
  end

  assign o_dec = r_dec;

endmodule
`default_nettype wire

// File: tb/tb_bin2dec.sv
`default_nettype none
// ============================================================================
// Module   : tb_bin2dec
// Brief    : Table and sweep stimulus for bin2dec with a queued scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bin2dec;

  logic       i_clk;
  logic       i_reset;
  logic [6:0] i_bin;
  logic       i_tens;
  logic       i_ones;
  logic [3:0] o_dec;

  int n_pass;
  int n_total;

  typedef struct {
    string      name;
    logic [3:0] exp;
  } sb_t;

  typedef struct {
    string      name;
    logic       rst;
    logic [6:0] bin;
    logic       tens;
    logic       ones;
    logic [3:0] exp;
  } vec_t;

  sb_t  sb_q[$];
  vec_t vecs[$];

  bin2dec u_dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_bin   (i_bin),
    .i_tens  (i_tens),
    .i_ones  (i_ones),
    .o_dec   (o_dec)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got stuck, required completion");
    $fatal(1);
  end

  function automatic logic [3:0] model(input int bin, input logic tens, input logic ones,
                                       input logic rst);
    int t;
    int o;
    if (rst) return 4'hF;
    if (bin >= 100) begin
      t = 9;
      o = 9;
    end else begin
      t = bin / 10;
      o = bin % 10;
    end
    if (tens && !ones) return 4'(t);
    if (ones && !tens) return 4'(o);
    return 4'hF;
  endfunction

  // Drive on the falling edge, expect after the next rising edge.
  task automatic step(input string name, input logic rst, input logic [6:0] bin,
                      input logic tens, input logic ones, input logic [3:0] exp);
    sb_t e;
    sb_t got;
    @(negedge i_clk);
    i_reset = rst;
    i_bin   = bin;
    i_tens  = tens;
    i_ones  = ones;
    e.name  = name;
    e.exp   = exp;
    sb_q.push_back(e);
    @(posedge i_clk);
    #1;
    got = sb_q.pop_front();
    n_total++;
    if (o_dec === got.exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: o_dec=%h required=%h", got.name, o_dec, got.exp);
    end
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    i_reset = 1'b1;
    i_bin   = 7'd0;
    i_tens  = 1'b0;
    i_ones  = 1'b0;

    vecs.push_back('{"pt0_ones",   1'b0, 7'd0,   1'b0, 1'b1, 4'h0});
    vecs.push_back('{"pt0_tens",   1'b0, 7'd0,   1'b1, 1'b0, 4'h0});
    vecs.push_back('{"pt9_ones",   1'b0, 7'd9,   1'b0, 1'b1, 4'h9});
    vecs.push_back('{"pt9_tens",   1'b0, 7'd9,   1'b1, 1'b0, 4'h0});
    vecs.push_back('{"pt10_ones",  1'b0, 7'd10,  1'b0, 1'b1, 4'h0});
    vecs.push_back('{"pt10_tens",  1'b0, 7'd10,  1'b1, 1'b0, 4'h1});
    vecs.push_back('{"pt57_ones",  1'b0, 7'd57,  1'b0, 1'b1, 4'h7});
    vecs.push_back('{"pt57_tens",  1'b0, 7'd57,  1'b1, 1'b0, 4'h5});
    vecs.push_back('{"pt99_ones",  1'b0, 7'd99,  1'b0, 1'b1, 4'h9});
    vecs.push_back('{"pt99_tens",  1'b0, 7'd99,  1'b1, 1'b0, 4'h9});
    vecs.push_back('{"pt5_tens",   1'b0, 7'd5,   1'b1, 1'b0, 4'h0});
    vecs.push_back('{"sat100_t",   1'b0, 7'd100, 1'b1, 1'b0, 4'h9});
    vecs.push_back('{"sat100_o",   1'b0, 7'd100, 1'b0, 1'b1, 4'h9});
    vecs.push_back('{"sat115_t",   1'b0, 7'd115, 1'b1, 1'b0, 4'h9});
    vecs.push_back('{"sat115_o",   1'b0, 7'd115, 1'b0, 1'b1, 4'h9});
    vecs.push_back('{"sat127_t",   1'b0, 7'd127, 1'b1, 1'b0, 4'h9});
    vecs.push_back('{"sat127_o",   1'b0, 7'd127, 1'b0, 1'b1, 4'h9});
    vecs.push_back('{"sel_none",   1'b0, 7'd37,  1'b0, 1'b0, 4'hF});
    vecs.push_back('{"sel_both",   1'b0, 7'd37,  1'b1, 1'b1, 4'hF});
    vecs.push_back('{"b2b_12_o",   1'b0, 7'd12,  1'b0, 1'b1, 4'h2});
    vecs.push_back('{"b2b_98_t",   1'b0, 7'd98,  1'b1, 1'b0, 4'h9});
    vecs.push_back('{"b2b_sel_x",  1'b0, 7'd64,  1'b1, 1'b0, 4'h6});
    vecs.push_back('{"b2b_sel_y",  1'b0, 7'd64,  1'b0, 1'b1, 4'h4});

    // Reset held two cycles with live inputs, then release.
    step("rst_c0", 1'b1, 7'd42, 1'b0, 1'b1, 4'hF);
    step("rst_c1", 1'b1, 7'd42, 1'b0, 1'b1, 4'hF);
    step("rst_rel", 1'b0, 7'd42, 1'b0, 1'b1, 4'h2);

    foreach (vecs[i]) begin
      step(vecs[i].name, vecs[i].rst, vecs[i].bin, vecs[i].tens, vecs[i].ones, vecs[i].exp);
    end

    for (int i = 0; i < 100; i++) begin
      step("sweep_ones", 1'b0, 7'(i), 1'b0, 1'b1, model(i, 1'b0, 1'b1, 1'b0));
      step("sweep_tens", 1'b0, 7'(i), 1'b1, 1'b0, model(i, 1'b1, 1'b0, 1'b0));
    end

    // Reset pulse in the middle of a sweep, then conversion resumes.
    for (int i = 60; i < 70; i++) begin
      logic r;
      r = (i == 64);
      step("midrst", r, 7'(i), 1'b0, 1'b1, model(i, 1'b0, 1'b1, r));
    end
    step("midrst_t", 1'b0, 7'd64, 1'b1, 1'b0, 4'h6);

    if (sb_q.size() != 0) begin
      n_total++;
      $display("FAIL scoreboard_drain: left=%0d required=0", sb_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
